// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_bus_arbiter                                                       |
// | Two-port arbiter (fetch / load-store) onto a 1-cycle memory macro.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module mem_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              mem_ready,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_owner_q, rd_owner_d;
  logic       w_m0_prio;

  // Grants are gated by rst so every output reads 0 while reset is held.
  always_comb begin
    w_m0_prio = (starve_cnt_q >= C_MAX_WAIT) && m0_req;
    m0_gnt    = !rst && mem_ready && (w_m0_prio || (m0_req && !m1_req));
    m1_gnt    = !rst && mem_ready && m1_req && !w_m0_prio;
  end

  always_comb begin
    mem_ce    = m0_gnt | m1_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m1_gnt) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end else if (m0_gnt) begin
      mem_addr  = m0_addr;
    end
  end

  always_comb begin
    m0_rvalid = rd_pend_q && !rd_owner_q;
    m1_rvalid = rd_pend_q && rd_owner_q;
    m0_rdata  = m0_rvalid ? mem_rdata : '0;
    m1_rdata  = m1_rvalid ? mem_rdata : '0;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (m0_gnt)
      starve_cnt_d = '0;
    else if (m0_req && mem_ready && (starve_cnt_q < C_MAX_WAIT))
      starve_cnt_d = starve_cnt_q + 4'd1;
    rd_pend_d  = m0_gnt || (m1_gnt && !m1_we);
    rd_owner_d = m1_gnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mem_bus_arbiter                                                    |
// | Directed + random bench with a transaction-level reference model.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_mem_bus_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_req, m1_req, m1_we, mem_ready;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              mem_ce, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_ready(mem_ready), .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory macro: 64 words, word-addressed by addr[7:2], 1-cycle read latency.
  logic [DATA_W-1:0] mem [64];
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  // Reference model: transaction view of the arbiter and a shadow memory.
  logic [DATA_W-1:0] ref_mem [64];
  int                ref_wait;
  bit                ref_pend;
  int                ref_owner;
  logic [DATA_W-1:0] ref_word;
  int                last_win;
  int                total = 0;
  int                bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit r, input bit q0, input logic [31:0] a0,
                        input bit q1, input bit we, input logic [31:0] a1,
                        input logic [31:0] wd, input bit rdy);
    rst = r; m0_req = q0; m0_addr = a0; m1_req = q1; m1_we = we;
    m1_addr = a1; m1_wdata = wd; mem_ready = rdy;
  endtask

  // One clock: check outputs mid-cycle, advance the model, move past the edge.
  task automatic step();
    int                win;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    bit                e_we, rv0, rv1;
    @(negedge clk);
    win = -1;
    if (!rst && mem_ready) begin
      if (m0_req && ref_wait >= MAX_WAIT) win = 0;
      else if (m1_req)                    win = 1;
      else if (m0_req)                    win = 0;
    end
    e_addr  = (win == 0) ? m0_addr : (win == 1) ? m1_addr : '0;
    e_wdata = (win == 1) ? m1_wdata : '0;
    e_we    = (win == 1) && m1_we;
    rv0     = !rst && ref_pend && ref_owner == 0;
    rv1     = !rst && ref_pend && ref_owner == 1;
    chk("m0_gnt", m0_gnt, win == 0);
    chk("m1_gnt", m1_gnt, win == 1);
    chk("mem_ce", mem_ce, win >= 0);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("m0_rvalid", m0_rvalid, rv0);
    chk("m1_rvalid", m1_rvalid, rv1);
    chk("m0_rdata", m0_rdata, rv0 ? ref_word : '0);
    chk("m1_rdata", m1_rdata, rv1 ? ref_word : '0);
    last_win = win;
    if (rst) begin
      ref_wait = 0;
      ref_pend = 0;
    end else begin
      if (win == 0) ref_wait = 0;
      else if (m0_req && mem_ready && ref_wait < MAX_WAIT) ref_wait++;
      ref_pend  = (win == 0) || (win == 1 && !m1_we);
      ref_owner = win;
      if (ref_pend) ref_word = ref_mem[e_addr[7:2]];
      if (e_we) ref_mem[e_addr[7:2]] = e_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit [11:0]   pat;
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      mem[i] = w;
      ref_mem[i] = w;
    end
    ref_wait = 0; ref_pend = 0; ref_owner = 0; ref_word = '0; last_win = -1;

    // Reset held with both requesting: everything quiet.
    set_in(1, 1, 32'h10, 1, 0, 32'h20, 32'h0, 1);
    step(); step();

    // First fetch after reset, then its read data.
    set_in(0, 1, 32'h10, 0, 0, 32'h0, 32'h0, 1);
    step();
    chk("first_fetch_gnt", last_win, 0);
    set_in(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1);
    step();

    // Single write, then idle cycle with no rvalid.
    set_in(0, 0, 32'h0, 1, 1, 32'h40, 32'hDEADBEEF, 1);
    step();
    set_in(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1);
    step();

    // Contention: m0 should win in cycles 5 and 10.
    set_in(0, 1, 32'h80, 1, 0, 32'hC0, 32'h0, 1);
    for (int i = 0; i < 12; i++) begin
      step();
      pat[i] = (last_win == 0);
    end
    chk("contention_pattern", pat, 12'b0010_0001_0000);

    // Backpressure: three stalled cycles, then m1 granted immediately.
    set_in(0, 1, 32'h84, 1, 0, 32'hC4, 32'h0, 0);
    step(); step(); step();
    mem_ready = 1;
    step();
    chk("bp_release_gnt", last_win, 1);

    // Pipelined fetches 0, 4, 8.
    set_in(0, 1, 32'h0, 0, 0, 32'h0, 32'h0, 1);
    step();
    m0_addr = 32'h4; step();
    m0_addr = 32'h8; step();
    m0_req = 0; step(); step();

    // Reset in the cycle after an m1 read grant suppresses the response.
    set_in(0, 0, 32'h0, 1, 0, 32'h50, 32'h0, 1);
    step();
    set_in(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1);
    step();
    set_in(0, 1, 32'h14, 0, 0, 32'h0, 32'h0, 1);
    step();
    chk("post_reset_gnt", last_win, 0);
    m0_req = 0;
    step();

    // Random traffic; requesters hold until granted.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      mem_ready = ($urandom_range(0, 4) != 0);
      if (!m0_req || last_win == 0) begin
        m0_req  = $urandom_range(0, 2) != 0;
        m0_addr = {24'h0, 6'($urandom), 2'b00};
      end
      if (!m1_req || last_win == 1) begin
        m1_req   = $urandom_range(0, 2) != 0;
        m1_we    = $urandom_range(0, 1);
        m1_addr  = {24'h0, 6'($urandom), 2'b00};
        m1_wdata = $urandom;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
